// File: rtl/mult_div_if.sv
// Core-side handshake and Hi/Lo read port of the iterative multiply/divide unit.
interface mult_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_mult;
  logic             is_unsigned;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_en;
  logic             rd_is_hi;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, is_mult, is_unsigned, a, b, rd_en, rd_is_hi,
    input  rd_data, busy, done, div_by_zero
  );

  modport slave (
    input  start, is_mult, is_unsigned, a, b, rd_en, rd_is_hi,
    output rd_data, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with Hi/Lo registers: one bit per cycle,
// shift-add multiply or restoring divide on operand magnitudes, sign fix-up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   hi, lo, opnd_b, a_orig;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               op_mult, neg_res, neg_rem, b_zero, done_r, dbz_r;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo, rem;

  always_comb begin
    a_neg = !bus.is_unsigned && bus.a[WIDTH-1];
    b_neg = !bus.is_unsigned && bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier}; carry re-enters at the top.
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_b};
    mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shifted remainder needs WIDTH+1 bits.
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opnd_b};
    div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

    prod    = neg_res ? -acc : acc;
    quo_raw = acc[WIDTH-1:0];
    rem_raw = acc[2*WIDTH-1:WIDTH];
    quo     = neg_res ? -quo_raw : quo_raw;
    rem     = neg_rem ? -rem_raw : rem_raw;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      opnd_b  <= '0;
      a_orig  <= '0;
      acc     <= '0;
      cnt     <= '0;
      op_mult <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          acc     <= {{WIDTH{1'b0}}, a_mag};
          opnd_b  <= b_mag;
          a_orig  <= bus.a;
          op_mult <= bus.is_mult;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          b_zero  <= (bus.b == '0);
          cnt     <= '0;
        end
        CALC: begin
          acc <= op_mult ? mul_nxt : div_nxt;
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          done_r <= 1'b1;
          if (op_mult) begin
            {hi, lo} <= prod;
          end else if (b_zero) begin
            lo    <= '1;
            hi    <= a_orig;
            dbz_r <= 1'b1;
          end else begin
            lo <= quo;
            hi <= rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.rd_data     = bus.rd_en ? (bus.rd_is_hi ? hi : lo) : '0;
endmodule
